paddle_ctrl: RTL

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/paddle_ctrl.sv
// Paddle controller for a two-player paddle game.
// Converts per-player joystick buttons (with frame-based acceleration) or
// raw analog positions into clamped, registered paddle positions, and turns
// a bouncy coin button into a fixed-length, one-per-press coin pulse.
// All game state advances only on the frame tick derived from vsync.

module paddle_ctrl #(
    parameter logic [7:0]  PAD_MIN      = 8'd0,
    parameter logic [7:0]  PAD_MAX      = 8'd239,
    parameter logic [7:0]  PAD_CENTER   = 8'd120,
    parameter int unsigned ACCEL_FRAMES = 8,
    parameter int unsigned COIN_FRAMES  = 4
) (
    input  logic       clk7_159,
    input  logic       _reset,
    input  logic       vsync,
    input  logic [1:0] joy_up,
    input  logic [1:0] joy_dn,
    input  logic       analog_mode,
    input  logic [7:0] analog1,
    input  logic [7:0] analog2,
    input  logic       coin_btn,
    output logic [7:0] paddle1_vpos,
    output logic [7:0] paddle2_vpos,
    output logic       coin_sw
);

    // Parameters narrowed once so every comparison below is width-matched.
    localparam logic [3:0] ACCEL_LIM = 4'(ACCEL_FRAMES);
    localparam logic [3:0] COIN_LAST = 4'(COIN_FRAMES - 1);
    localparam int         NPLAYER   = 2;

    typedef enum logic [1:0] {
        SPD_IDLE,
        SPD_SLOW,
        SPD_MED,
        SPD_FAST
    } speed_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } dir_e;

    typedef enum logic [1:0] {
        COIN_ARMED,    // released, counting high samples toward a press
        COIN_PULSE,    // coin_sw asserted, counting pulse frames
        COIN_RELEASE   // pulse done, counting low samples toward release
    } coin_e;

    // ------------------------------------------------------------------
    // Frame tick
    // ------------------------------------------------------------------
    logic vsync_q;
    logic tick;

    // Register vsync and raise tick for one cycle after its sampled rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            vsync_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vsync_q <= vsync;
            tick    <= vsync & ~vsync_q;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic dir_e resolve_dir(input logic up, input logic dn);
        if (up && !dn)      return DIR_UP;
        else if (dn && !up) return DIR_DN;
        else                return DIR_NONE;
    endfunction

    function automatic logic [3:0] step_of(input speed_e spd);
        case (spd)
            SPD_SLOW: return 4'd1;
            SPD_MED:  return 4'd2;
            SPD_FAST: return 4'd4;
            default:  return 4'd0;
        endcase
    endfunction

    function automatic speed_e next_speed(input speed_e spd);
        case (spd)
            SPD_SLOW: return SPD_MED;
            SPD_MED:  return SPD_FAST;
            default:  return SPD_FAST;
        endcase
    endfunction

    // Signed 10-bit intermediate so an underflow past zero can never alias
    // onto a large positive value and clamp to the wrong end.
    function automatic logic [7:0] clamp_pos(input logic signed [9:0] v);
        if (v < $signed({2'b00, PAD_MIN}))      return PAD_MIN;
        else if (v > $signed({2'b00, PAD_MAX})) return PAD_MAX;
        else                                    return v[7:0];
    endfunction

    function automatic logic [7:0] move_pos(input logic [7:0] pos,
                                            input dir_e       dir,
                                            input logic [3:0] step);
        logic signed [9:0] p;
        logic signed [9:0] s;
        p = $signed({2'b00, pos});
        s = $signed({6'b000000, step});
        if (dir == DIR_UP) return clamp_pos(p - s);
        else               return clamp_pos(p + s);
    endfunction

    // ------------------------------------------------------------------
    // Per-player speed FSM and position
    // ------------------------------------------------------------------
    speed_e     spd_q  [NPLAYER];
    speed_e     spd_d  [NPLAYER];
    dir_e       dir_q  [NPLAYER];
    dir_e       dir_d  [NPLAYER];
    logic [3:0] hold_q [NPLAYER];
    logic [3:0] hold_d [NPLAYER];
    logic [7:0] pos_q  [NPLAYER];
    logic [7:0] pos_d  [NPLAYER];

    // Hold speed, direction, hold counter and position for both players.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            for (int p = 0; p < NPLAYER; p++) begin
                spd_q[p]  <= SPD_IDLE;
                dir_q[p]  <= DIR_NONE;
                hold_q[p] <= 4'd0;
                pos_q[p]  <= PAD_CENTER;
            end
        end else begin
            for (int p = 0; p < NPLAYER; p++) begin
                spd_q[p]  <= spd_d[p];
                dir_q[p]  <= dir_d[p];
                hold_q[p] <= hold_d[p];
                pos_q[p]  <= pos_d[p];
            end
        end
    end

    // Next speed/direction/position per player; nothing moves between ticks.
    // NOTE: every output of this block is defaulted to its held value first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        for (int p = 0; p < NPLAYER; p++) begin
            spd_d[p]  = spd_q[p];
            dir_d[p]  = dir_q[p];
            hold_d[p] = hold_q[p];
            pos_d[p]  = pos_q[p];

            if (tick) begin
                if (analog_mode) begin
                    spd_d[p]  = SPD_IDLE;
                    dir_d[p]  = DIR_NONE;
                    hold_d[p] = 4'd0;
                    pos_d[p]  = clamp_pos($signed({2'b00, (p == 0) ? analog1 : analog2}));
                end else if (resolve_dir(joy_up[p], joy_dn[p]) == DIR_NONE) begin
                    spd_d[p]  = SPD_IDLE;
                    dir_d[p]  = DIR_NONE;
                    hold_d[p] = 4'd0;
                end else if (spd_q[p] == SPD_IDLE ||
                             resolve_dir(joy_up[p], joy_dn[p]) != dir_q[p]) begin
                    // Fresh press or reversal: restart slow, move one step now.
                    spd_d[p]  = SPD_SLOW;
                    dir_d[p]  = resolve_dir(joy_up[p], joy_dn[p]);
                    hold_d[p] = 4'd0;
                    pos_d[p]  = move_pos(pos_q[p], dir_d[p], 4'd1);
                end else begin
                    // Continued hold: move at current speed, then count frames.
                    pos_d[p] = move_pos(pos_q[p], dir_q[p], step_of(spd_q[p]));
                    if (hold_q[p] + 4'd1 == ACCEL_LIM) begin
                        spd_d[p]  = next_speed(spd_q[p]);
                        hold_d[p] = 4'd0;
                    end else if (hold_q[p] != 4'hF) begin
                        hold_d[p] = hold_q[p] + 4'd1;
                    end
                end
            end
        end
    end

    assign paddle1_vpos = pos_q[0];
    assign paddle2_vpos = pos_q[1];

    // ------------------------------------------------------------------
    // Coin debouncer and pulse generator
    // ------------------------------------------------------------------
    coin_e      coin_q, coin_d;
    logic [1:0] samp_q, samp_d;   // consecutive matching samples seen
    logic [3:0] left_q, left_d;   // pulse frames remaining after this one
    logic       sw_q, sw_d;

    // Hold debouncer state and the registered coin pulse.
    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            coin_q <= COIN_ARMED;
            samp_q <= 2'd0;
            left_q <= 4'd0;
            sw_q   <= 1'b0;
        end else begin
            coin_q <= coin_d;
            samp_q <= samp_d;
            left_q <= left_d;
            sw_q   <= sw_d;
        end
    end

    // Accept a press after three high ticks, pulse, then demand three low ticks.
    always_comb begin
        coin_d = coin_q;
        samp_d = samp_q;
        left_d = left_q;
        sw_d   = sw_q;

        if (tick) begin
            case (coin_q)
                COIN_ARMED: begin
                    if (coin_btn) begin
                        if (samp_q == 2'd2) begin
                            coin_d = COIN_PULSE;
                            samp_d = 2'd0;
                            left_d = COIN_LAST;
                            sw_d   = 1'b1;
                        end else begin
                            samp_d = samp_q + 2'd1;
                        end
                    end else begin
                        samp_d = 2'd0;
                    end
                end
                COIN_PULSE: begin
                    if (left_q == 4'd0) begin
                        coin_d = COIN_RELEASE;
                        samp_d = 2'd0;
                        sw_d   = 1'b0;
                    end else begin
                        left_d = left_q - 4'd1;
                    end
                end
                COIN_RELEASE: begin
                    if (!coin_btn) begin
                        if (samp_q == 2'd2) begin
                            coin_d = COIN_ARMED;
                            samp_d = 2'd0;
                        end else begin
                            samp_d = samp_q + 2'd1;
                        end
                    end else begin
                        samp_d = 2'd0;
                    end
                end
                default: begin
                    coin_d = COIN_ARMED;
                    samp_d = 2'd0;
                    sw_d   = 1'b0;
                end
            endcase
        end
    end

    assign coin_sw = sw_q;

endmodule
